// File: rtl/sisc.sv
// sisc: multi-cycle 32-bit register-register CPU core with a 16x32 register file.
// Instructions arrive on IR and step through FETCH/DECODE/EXECUTE/WRITEBACK.
module sisc (
  input  logic        CLK,
  input  logic        RST_F,
  input  logic [31:0] IR,
  output logic        HALTED,
  output logic [3:0]  STAT,
  output logic        WB_EN,
  output logic [3:0]  WB_ADDR,
  output logic [31:0] WB_DATA
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned SW   = 5;

  localparam logic [3:0] OP_ALU = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] F_ADD  = 4'd1;
  localparam logic [3:0] F_SUB  = 4'd2;
  localparam logic [3:0] F_NOT  = 4'd4;
  localparam logic [3:0] F_OR   = 4'd5;
  localparam logic [3:0] F_AND  = 4'd6;
  localparam logic [3:0] F_XOR  = 4'd7;
  localparam logic [3:0] F_ROTR = 4'd8;
  localparam logic [3:0] F_ROTL = 4'd9;
  localparam logic [3:0] F_SHFR = 4'd10;
  localparam logic [3:0] F_SHFL = 4'd11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] res_q;
  logic [3:0]      flags_q;
  logic            we_q;
  logic [XLEN-1:0] regs [NREG];

  logic [3:0]      opcode;
  logic            imm_form;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [3:0]      func;

  assign opcode   = ir_q[31:28];
  assign imm_form = ir_q[27];
  assign rs1      = ir_q[23:20];
  assign rs2      = ir_q[19:16];
  assign rd       = imm_form ? ir_q[19:16] : ir_q[15:12];
  assign func     = ir_q[3:0];

  // State register
  always_ff @(posedge CLK or posedge RST_F) begin
    if (RST_F) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; HLT diverts from DECODE into the absorbing HALT state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // ALU: b_q already holds the zero-extended immediate in the immediate form
  logic [XLEN:0]     sum, diff;
  logic [2*XLEN-1:0] rotr64, rotl64;
  logic [SW-1:0]     sh;
  logic [XLEN-1:0]   alu_res;
  logic              alu_c, alu_v, alu_we;

  assign sh     = b_q[SW-1:0];
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign diff   = {1'b0, a_q} - {1'b0, b_q};
  assign rotr64 = {a_q, a_q} >> sh;
  assign rotl64 = {a_q, a_q} << sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_we  = 1'b0;
    if (opcode == OP_ALU) begin
      if (imm_form) begin
        alu_res = sum[XLEN-1:0];
        alu_c   = sum[XLEN];
        alu_v   = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
        alu_we  = 1'b1;
      end else begin
        alu_we = 1'b1;
        case (func)
          F_ADD: begin
            alu_res = sum[XLEN-1:0];
            alu_c   = sum[XLEN];
            alu_v   = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
          end
          F_SUB: begin
            alu_res = diff[XLEN-1:0];
            alu_c   = diff[XLEN];
            alu_v   = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
          end
          F_NOT:   alu_res = ~b_q;
          F_OR:    alu_res = a_q | b_q;
          F_AND:   alu_res = a_q & b_q;
          F_XOR:   alu_res = a_q ^ b_q;
          F_ROTR:  alu_res = rotr64[XLEN-1:0];
          F_ROTL:  alu_res = rotl64[2*XLEN-1:XLEN];
          F_SHFR:  alu_res = a_q >> sh;
          F_SHFL:  alu_res = a_q << sh;
          default: alu_we  = 1'b0;
        endcase
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ir_q[26:24], rotr64[2*XLEN-1:XLEN], rotl64[XLEN-1:0]};

  // Datapath and register file; reset aborts any in-flight instruction
  always_ff @(posedge CLK or posedge RST_F) begin
    if (RST_F) begin
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      we_q    <= 1'b0;
      HALTED  <= 1'b0;
      STAT    <= '0;
      WB_EN   <= 1'b0;
      WB_ADDR <= '0;
      WB_DATA <= '0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= XLEN'(i);
    end else begin
      WB_EN <= 1'b0;
      case (state_q)
        S_FETCH: ir_q <= IR;
        S_DECODE: begin
          a_q <= regs[rs1];
          b_q <= imm_form ? XLEN'(ir_q[15:0]) : regs[rs2];
          if (opcode == OP_HLT) HALTED <= 1'b1;
        end
        S_EXECUTE: begin
          res_q   <= alu_res;
          flags_q <= {alu_c, alu_v, alu_res[31], (alu_res == '0)};
          we_q    <= alu_we;
        end
        S_WRITEBACK: begin
          if (we_q) begin
            regs[rd] <= res_q;
            WB_EN    <= 1'b1;
            WB_ADDR  <= rd;
            WB_DATA  <= res_q;
            STAT     <= flags_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc.sv
// tb_sisc: directed self-checking bench for the sisc core.
// Each instruction is launched with the core in FETCH and observed 4 edges later.
module tb_sisc;

  logic        CLK;
  logic        RST_F;
  logic [31:0] IR;
  logic        HALTED;
  logic [3:0]  STAT;
  logic        WB_EN;
  logic [3:0]  WB_ADDR;
  logic [31:0] WB_DATA;

  int tests;
  int fails;

  sisc dut (
    .CLK     (CLK),
    .RST_F   (RST_F),
    .IR      (IR),
    .HALTED  (HALTED),
    .STAT    (STAT),
    .WB_EN   (WB_EN),
    .WB_ADDR (WB_ADDR),
    .WB_DATA (WB_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present an instruction in FETCH and step through its four states
  task automatic exec(input logic [31:0] instr);
    IR = instr;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_F = 1'b1;
    IR    = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (HALTED !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", HALTED); end
    tests++; if (STAT !== 4'h0) begin fails++; $display("FAIL reset_stat: got %b want 0000", STAT); end
    tests++; if (WB_EN !== 1'b0) begin fails++; $display("FAIL reset_wb_en: got %b want 0", WB_EN); end
    tests++; if (WB_ADDR !== 4'h0) begin fails++; $display("FAIL reset_wb_addr: got %h want 0", WB_ADDR); end
    tests++; if (WB_DATA !== 32'h0) begin fails++; $display("FAIL reset_wb_data: got %h want 0", WB_DATA); end
    @(negedge CLK);
    RST_F = 1'b0;
  endtask

  task automatic test_nop_add;
    exec(32'h0000_0000);
    tests++; if (WB_EN !== 1'b0) begin fails++; $display("FAIL nop_wb_en: got %b want 0", WB_EN); end
    IR = 32'h8012_3001;
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK); #1;
      tests++; if (WB_EN !== 1'b0) begin fails++; $display("FAIL add_early_wb_en cycle %0d: got %b want 0", c, WB_EN); end
    end
    @(posedge CLK); #1;
    tests++; if (WB_EN !== 1'b1) begin fails++; $display("FAIL add_wb_en: got %b want 1", WB_EN); end
    tests++; if (WB_ADDR !== 4'd3) begin fails++; $display("FAIL add_wb_addr: got %h want 3", WB_ADDR); end
    tests++; if (WB_DATA !== 32'd3) begin fails++; $display("FAIL add_wb_data: got %h want 3", WB_DATA); end
    tests++; if (STAT !== 4'b0000) begin fails++; $display("FAIL add_stat: got %b want 0000", STAT); end
  endtask

  task automatic test_sub_not;
    exec(32'h8012_3002);
    tests++; if (WB_DATA !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sub_data: got %h want ffffffff", WB_DATA); end
    tests++; if (STAT !== 4'b1010) begin fails++; $display("FAIL sub_stat: got %b want 1010", STAT); end
    exec(32'h8012_3004);
    tests++; if (WB_DATA !== 32'hFFFF_FFFD) begin fails++; $display("FAIL not_data: got %h want fffffffd", WB_DATA); end
    tests++; if (STAT !== 4'b0010) begin fails++; $display("FAIL not_stat: got %b want 0010", STAT); end
  endtask

  task automatic test_logic;
    logic [31:0] exp_data [3];
    logic [3:0]  exp_stat [3];
    exp_data[0] = 32'd3; exp_stat[0] = 4'b0000;
    exp_data[1] = 32'd0; exp_stat[1] = 4'b0001;
    exp_data[2] = 32'd3; exp_stat[2] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      exec(32'h8012_3005 + 32'(i));
      tests++; if (WB_DATA !== exp_data[i]) begin fails++; $display("FAIL logic_data func %0d: got %h want %h", 5 + i, WB_DATA, exp_data[i]); end
      tests++; if (STAT !== exp_stat[i]) begin fails++; $display("FAIL logic_stat func %0d: got %b want %b", 5 + i, STAT, exp_stat[i]); end
    end
  endtask

  task automatic test_shift;
    logic [31:0] exp_data [4];
    logic [3:0]  exp_stat [4];
    exp_data[0] = 32'h4000_0000; exp_stat[0] = 4'b0000;
    exp_data[1] = 32'd4;         exp_stat[1] = 4'b0000;
    exp_data[2] = 32'd0;         exp_stat[2] = 4'b0001;
    exp_data[3] = 32'd4;         exp_stat[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exec(32'h8012_3008 + 32'(i));
      tests++; if (WB_DATA !== exp_data[i]) begin fails++; $display("FAIL shift_data func %0d: got %h want %h", 8 + i, WB_DATA, exp_data[i]); end
      tests++; if (STAT !== exp_stat[i]) begin fails++; $display("FAIL shift_stat func %0d: got %b want %b", 8 + i, STAT, exp_stat[i]); end
    end
  endtask

  task automatic test_flags;
    exec(32'h8012_3002);
    exec(32'h8031_4001);
    tests++; if (WB_DATA !== 32'h0) begin fails++; $display("FAIL carry_data: got %h want 0", WB_DATA); end
    tests++; if (STAT !== 4'b1001) begin fails++; $display("FAIL carry_stat: got %b want 1001", STAT); end
    exec(32'h8011_6008);
    tests++; if (WB_DATA !== 32'h8000_0000) begin fails++; $display("FAIL rotr1_data: got %h want 80000000", WB_DATA); end
    tests++; if (STAT !== 4'b0010) begin fails++; $display("FAIL rotr1_stat: got %b want 0010", STAT); end
    exec(32'h8061_7002);
    tests++; if (WB_DATA !== 32'h7FFF_FFFF) begin fails++; $display("FAIL ovf_data: got %h want 7fffffff", WB_DATA); end
    tests++; if (STAT !== 4'b0100) begin fails++; $display("FAIL ovf_stat: got %b want 0100", STAT); end
  endtask

  task automatic test_no_write;
    logic [31:0] nw [4];
    nw[0] = 32'h8012_3000;
    nw[1] = 32'h8012_3003;
    nw[2] = 32'h8012_300C;
    nw[3] = 32'h5012_3001;
    exec(32'h8012_3002);
    for (int i = 0; i < 4; i++) begin
      exec(nw[i]);
      tests++; if (WB_EN !== 1'b0) begin fails++; $display("FAIL nowrite_wb_en %h: got %b want 0", nw[i], WB_EN); end
      tests++; if (STAT !== 4'b1010) begin fails++; $display("FAIL nowrite_stat %h: got %b want 1010", nw[i], STAT); end
      tests++; if (WB_DATA !== 32'hFFFF_FFFF) begin fails++; $display("FAIL nowrite_data %h: got %h want ffffffff", nw[i], WB_DATA); end
    end
  endtask

  task automatic test_isolation;
    IR = 32'h8012_3001;
    @(posedge CLK); #1;
    IR = 32'h8012_3002;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (WB_DATA !== 32'd3) begin fails++; $display("FAIL isolation_data: got %h want 3", WB_DATA); end
    tests++; if (STAT !== 4'b0000) begin fails++; $display("FAIL isolation_stat: got %b want 0000", STAT); end
  endtask

  task automatic test_addi_hold;
    int pulses;
    exec(32'h8812_2224);
    tests++; if (WB_DATA !== 32'h0000_2225) begin fails++; $display("FAIL addi_data: got %h want 00002225", WB_DATA); end
    tests++; if (WB_ADDR !== 4'd2) begin fails++; $display("FAIL addi_addr: got %h want 2", WB_ADDR); end
    tests++; if (STAT !== 4'b0000) begin fails++; $display("FAIL addi_stat: got %b want 0000", STAT); end
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      if (WB_EN === 1'b1) begin
        pulses++;
        tests++; if (WB_DATA !== 32'h0000_2225) begin fails++; $display("FAIL hold_data cycle %0d: got %h want 00002225", c, WB_DATA); end
      end
    end
    tests++; if (pulses != 2) begin fails++; $display("FAIL hold_pulses: got %0d want 2", pulses); end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_back_to_back;
    exec(32'h8011_1001);
    tests++; if (WB_DATA !== 32'd2) begin fails++; $display("FAIL rd_eq_rs_first: got %h want 2", WB_DATA); end
    exec(32'h8011_1001);
    tests++; if (WB_DATA !== 32'd4) begin fails++; $display("FAIL rd_eq_rs_second: got %h want 4", WB_DATA); end
  endtask

  task automatic test_halt;
    int pulses;
    IR = 32'hF023_0000;
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (HALTED !== 1'b1) begin fails++; $display("FAIL halt_flag: got %b want 1", HALTED); end
    IR = 32'h8012_3001;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      if (WB_EN === 1'b1) pulses++;
      if (c == 5) IR = 32'h8812_2224;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL halt_wb_pulses: got %0d want 0", pulses); end
    tests++; if (HALTED !== 1'b1) begin fails++; $display("FAIL halt_sticky: got %b want 1", HALTED); end
  endtask

  task automatic test_reset_mid;
    RST_F = 1'b1;
    #2;
    tests++; if (HALTED !== 1'b0) begin fails++; $display("FAIL unhalt: got %b want 0", HALTED); end
    @(negedge CLK);
    RST_F = 1'b0;
    exec(32'h8012_1002);
    tests++; if (WB_DATA !== 32'hFFFF_FFFF) begin fails++; $display("FAIL pre_abort_data: got %h want ffffffff", WB_DATA); end
    tests++; if (STAT !== 4'b1010) begin fails++; $display("FAIL pre_abort_stat: got %b want 1010", STAT); end
    IR = 32'h8012_3001;
    repeat (2) @(posedge CLK);
    #1;
    RST_F = 1'b1;
    #1;
    tests++; if (STAT !== 4'h0) begin fails++; $display("FAIL abort_stat: got %b want 0000", STAT); end
    tests++; if (WB_DATA !== 32'h0) begin fails++; $display("FAIL abort_data: got %h want 0", WB_DATA); end
    tests++; if (WB_ADDR !== 4'h0) begin fails++; $display("FAIL abort_addr: got %h want 0", WB_ADDR); end
    tests++; if (WB_EN !== 1'b0) begin fails++; $display("FAIL abort_wb_en: got %b want 0", WB_EN); end
    @(negedge CLK);
    RST_F = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      exec(32'h8804_0000 | (32'(r) << 20));
      tests++; if (WB_DATA !== 32'(r)) begin fails++; $display("FAIL reg_restore R%0d: got %h want %h", r, WB_DATA, 32'(r)); end
      tests++; if (WB_ADDR !== 4'd4) begin fails++; $display("FAIL reg_restore_addr R%0d: got %h want 4", r, WB_ADDR); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST_F = 1'b1;
    IR    = 32'h0;
    test_reset;
    test_nop_add;
    test_sub_not;
    test_logic;
    test_shift;
    test_flags;
    test_no_write;
    test_isolation;
    test_addi_hold;
    test_back_to_back;
    test_halt;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
